// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : FSM state encodings (also visible on o_state)
//   FWD_*        : EX operand forwarding selects
//   PC_SRC_SEQ   : pc_src value meaning "no redirect"
//   fwd_sel()    : forwarding priority for one EX source operand
package pipeline_hazard_ctl_pkg;

    typedef enum logic [2:0] {
        ST_FILL     = 3'b000,
        ST_RUN      = 3'b001,
        ST_MEM_WAIT = 3'b010,
        ST_DRAIN    = 3'b011,
        ST_HALTED   = 3'b100
    } state_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b01;
    localparam logic [1:0] FWD_MEM    = 2'b10;
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctl_forward_unit.sv
// forward_unit: combinational EX operand forwarding for both sources.
//   i_rs1_e, i_rs2_e              : EX source registers
//   i_rd_m, i_reg_write_m         : MEM destination / write enable
//   i_rd_w, i_reg_write_w         : WB destination / write enable
//   o_fwd_a_e, o_fwd_b_e          : 00 regfile, 01 from WB, 10 from MEM
module forward_unit
    import pipeline_hazard_ctl_pkg::*;
(
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd_a_e,
    output logic [1:0] o_fwd_b_e
);

    always_comb begin
        o_fwd_a_e = fwd_sel(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
        o_fwd_b_e = fwd_sel(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
    end

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// pipeline_hazard_ctl: sequencing and hazard controller for the 5-stage
// RISC-V datapath. Owns the FILL/RUN/MEM_WAIT/DRAIN/HALTED FSM, resolves
// load-use and control hazards, freezes the pipe on dmem busy, and
// forwards EX operands.
//   i_clk, i_rst (sync, active-low), i_clk_en (state update enable)
//   i_rs1_d/i_rs2_d   : ID sources      i_rs1_e/i_rs2_e : EX sources
//   i_rd_e/m/w        : EX/MEM/WB dests i_load_e        : EX is a load
//   i_reg_write_m/w   : MEM/WB writes   i_pc_src_e      : !=0 redirect
//   i_dmem_busy_m     : dmem not ready  i_halt_req      : level halt
//   o_pc_wr_en_h, o_if_id_stall_h, o_if_id_flush_h, o_id_ex_flush_h,
//   o_freeze_h, o_fwd_a_e/o_fwd_b_e, o_state, o_halted, o_mem_timeout
module pipeline_hazard_ctl
    import pipeline_hazard_ctl_pkg::*;
#(
    parameter int FILL_CYCLES  = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_WAIT     = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_en,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    input  logic [4:0] i_rs1_e,
    input  logic [4:0] i_rs2_e,
    input  logic [4:0] i_rd_e,
    input  logic [4:0] i_rd_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_load_e,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    input  logic [1:0] i_pc_src_e,
    input  logic       i_dmem_busy_m,
    input  logic       i_halt_req,
    output logic       o_pc_wr_en_h,
    output logic       o_if_id_stall_h,
    output logic       o_if_id_flush_h,
    output logic       o_id_ex_flush_h,
    output logic       o_freeze_h,
    output logic [1:0] o_fwd_a_e,
    output logic [1:0] o_fwd_b_e,
    output logic [2:0] o_state,
    output logic       o_halted,
    output logic       o_mem_timeout
);

    localparam logic [7:0] FILL_LAST  = 8'(FILL_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);

    state_t     r_state, r_saved, w_state_nxt, w_saved_nxt, w_eff;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_wait_cnt, w_wait_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       w_redirect, w_load_use, w_busy_act;
    logic [1:0] w_fwd_a, w_fwd_b;

    forward_unit u_fwd (
        .i_rs1_e       (i_rs1_e),
        .i_rs2_e       (i_rs2_e),
        .i_rd_m        (i_rd_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_m (i_reg_write_m),
        .i_reg_write_w (i_reg_write_w),
        .o_fwd_a_e     (w_fwd_a),
        .o_fwd_b_e     (w_fwd_b)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_FILL;
            r_saved    <= ST_RUN;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (i_clk_en) begin
            r_state    <= w_state_nxt;
            r_saved    <= w_saved_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        o_pc_wr_en_h    = 1'b0;
        o_if_id_stall_h = 1'b0;
        o_if_id_flush_h = 1'b0;
        o_id_ex_flush_h = 1'b0;
        o_freeze_h      = 1'b0;
        o_fwd_a_e       = w_fwd_a;
        o_fwd_b_e       = w_fwd_b;
        o_state         = r_state;
        o_halted        = (r_state == ST_HALTED);
        o_mem_timeout   = r_timeout;

        w_redirect = (i_pc_src_e != PC_SRC_SEQ);
        w_load_use = i_load_e && (i_rd_e != 5'd0) &&
                     ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

        // The cycle busy drops in MEM_WAIT behaves exactly like a cycle of
        // the state we came from, so decode on that "effective" state.
        w_eff = (r_state == ST_MEM_WAIT && !i_dmem_busy_m) ? r_saved : r_state;
        w_busy_act = i_dmem_busy_m &&
                     (w_eff == ST_RUN || w_eff == ST_DRAIN || w_eff == ST_MEM_WAIT);

        w_state_nxt   = w_eff;
        w_saved_nxt   = r_saved;
        w_cnt_nxt     = r_cnt;
        w_wait_nxt    = '0;
        w_timeout_nxt = r_timeout;

        if (w_busy_act) begin
            o_freeze_h      = 1'b1;
            o_if_id_stall_h = 1'b1;
            w_wait_nxt      = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + 8'd1;
            if (w_wait_nxt == WAIT_MAX)
                w_timeout_nxt = 1'b1;
            if (w_eff != ST_MEM_WAIT) begin
                w_saved_nxt = w_eff;
                w_state_nxt = ST_MEM_WAIT;
            end
        end else begin
            case (w_eff)
                ST_FILL: begin
                    o_pc_wr_en_h    = 1'b1;
                    o_if_id_flush_h = 1'b1;
                    o_id_ex_flush_h = 1'b1;
                    if (r_cnt == FILL_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        o_pc_wr_en_h    = 1'b1;
                        o_if_id_flush_h = 1'b1;
                        o_id_ex_flush_h = 1'b1;
                    end else if (w_load_use) begin
                        o_if_id_stall_h = 1'b1;
                        o_id_ex_flush_h = 1'b1;
                    end else begin
                        o_pc_wr_en_h = 1'b1;
                    end
                    if (i_halt_req) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_DRAIN: begin
                    o_pc_wr_en_h    = w_redirect;
                    o_if_id_flush_h = 1'b1;
                    o_id_ex_flush_h = w_redirect;
                    if (r_cnt == DRAIN_LAST) begin
                        w_state_nxt = ST_HALTED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_HALTED: begin
                    o_if_id_flush_h = 1'b1;
                    o_id_ex_flush_h = 1'b1;
                    if (!i_halt_req) begin
                        w_state_nxt = ST_FILL;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (!i_rst) begin
            o_pc_wr_en_h    = 1'b0;
            o_if_id_stall_h = 1'b0;
            o_if_id_flush_h = 1'b1;
            o_id_ex_flush_h = 1'b1;
            o_freeze_h      = 1'b0;
            o_fwd_a_e       = FWD_RF;
            o_fwd_b_e       = FWD_RF;
            o_state         = '0;
            o_halted        = 1'b0;
            o_mem_timeout   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Self-checking bench for pipeline_hazard_ctl: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a behavioural model of the controller.
module tb_pipeline_hazard_ctl;

    localparam int M_FILL = 0, M_RUN = 1, M_WAIT = 2, M_DRAIN = 3, M_HALT = 4;
    localparam int FILL_N = 1, DRAIN_N = 3, WAIT_N = 255;

    logic       i_clk = 1'b0;
    logic       i_rst, i_clk_en;
    logic [4:0] i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w;
    logic       i_load_e, i_reg_write_m, i_reg_write_w, i_dmem_busy_m, i_halt_req;
    logic [1:0] i_pc_src_e;
    logic       o_pc_wr_en_h, o_if_id_stall_h, o_if_id_flush_h, o_id_ex_flush_h, o_freeze_h;
    logic [1:0] o_fwd_a_e, o_fwd_b_e;
    logic [2:0] o_state;
    logic       o_halted, o_mem_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: mode, where to resume after a memory wait, remaining
    // fill/drain cycles, consecutive busy cycles, sticky timeout
    int m_mode, m_ret, m_fill_left, m_drain_left, m_streak;
    bit m_timeout;

    always #5 i_clk = ~i_clk;

    pipeline_hazard_ctl #(.FILL_CYCLES(FILL_N), .DRAIN_CYCLES(DRAIN_N), .MAX_WAIT(WAIT_N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d), .i_rs1_e(i_rs1_e), .i_rs2_e(i_rs2_e),
        .i_rd_e(i_rd_e), .i_rd_m(i_rd_m), .i_rd_w(i_rd_w), .i_load_e(i_load_e),
        .i_reg_write_m(i_reg_write_m), .i_reg_write_w(i_reg_write_w),
        .i_pc_src_e(i_pc_src_e), .i_dmem_busy_m(i_dmem_busy_m), .i_halt_req(i_halt_req),
        .o_pc_wr_en_h(o_pc_wr_en_h), .o_if_id_stall_h(o_if_id_stall_h),
        .o_if_id_flush_h(o_if_id_flush_h), .o_id_ex_flush_h(o_id_ex_flush_h),
        .o_freeze_h(o_freeze_h), .o_fwd_a_e(o_fwd_a_e), .o_fwd_b_e(o_fwd_b_e),
        .o_state(o_state), .o_halted(o_halted), .o_mem_timeout(o_mem_timeout)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (i_reg_write_m && i_rd_m == rs) return 2'b10;
        if (i_reg_write_w && i_rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit busy_counts(input int eff);
        return i_dmem_busy_m && (eff == M_RUN || eff == M_DRAIN || eff == M_WAIT);
    endfunction

    function automatic int eff_mode();
        return (m_mode == M_WAIT && !i_dmem_busy_m) ? m_ret : m_mode;
    endfunction

    // Expected outputs from the rules, then compared against the DUT.
    task automatic compare_model();
        bit pc, st, ff, ef, fz;
        bit redir, lu;
        int eff;
        logic [1:0] fa, fb;
        eff   = eff_mode();
        redir = (i_pc_src_e != 2'b00);
        lu    = i_load_e && i_rd_e != 0 && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
        {pc, st, ff, ef, fz} = '0;
        fa = ref_fwd(i_rs1_e);
        fb = ref_fwd(i_rs2_e);
        if (!i_rst) begin
            ff = 1; ef = 1; fa = 0; fb = 0;
        end else if (busy_counts(eff)) begin
            fz = 1; st = 1;
        end else if (eff == M_FILL) begin
            pc = 1; ff = 1; ef = 1;
        end else if (eff == M_RUN) begin
            if (redir) begin pc = 1; ff = 1; ef = 1; end
            else if (lu) begin st = 1; ef = 1; end
            else pc = 1;
        end else if (eff == M_DRAIN) begin
            pc = redir; ff = 1; ef = redir;
        end else begin
            ff = 1; ef = 1;
        end
        chk("pc_wr_en", 8'(o_pc_wr_en_h), 8'(pc));
        chk("if_id_stall", 8'(o_if_id_stall_h), 8'(st));
        chk("if_id_flush", 8'(o_if_id_flush_h), 8'(ff));
        chk("id_ex_flush", 8'(o_id_ex_flush_h), 8'(ef));
        chk("freeze", 8'(o_freeze_h), 8'(fz));
        chk("fwd_a", 8'(o_fwd_a_e), 8'(fa));
        chk("fwd_b", 8'(o_fwd_b_e), 8'(fb));
        chk("state", 8'(o_state), i_rst ? 8'(m_mode) : 8'd0);
        chk("halted", 8'(o_halted), 8'(i_rst && m_mode == M_HALT));
        chk("timeout", 8'(o_mem_timeout), 8'(i_rst && m_timeout));
    endtask

    task automatic model_step();
        int eff;
        if (!i_rst) begin
            m_mode = M_FILL; m_fill_left = FILL_N; m_streak = 0; m_timeout = 0; m_ret = M_RUN;
        end else if (i_clk_en) begin
            eff = eff_mode();
            if (busy_counts(eff)) begin
                if (m_streak < WAIT_N) m_streak++;
                if (m_streak == WAIT_N) m_timeout = 1;
                if (eff != M_WAIT) begin m_ret = eff; m_mode = M_WAIT; end
            end else begin
                m_streak = 0;
                m_mode = eff;
                case (eff)
                    M_FILL:  begin m_fill_left--; if (m_fill_left == 0) m_mode = M_RUN; end
                    M_RUN:   if (i_halt_req) begin m_mode = M_DRAIN; m_drain_left = DRAIN_N; end
                    M_DRAIN: begin m_drain_left--; if (m_drain_left == 0) m_mode = M_HALT; end
                    M_HALT:  if (!i_halt_req) begin m_mode = M_FILL; m_fill_left = FILL_N; end
                    default: m_mode = M_FILL;
                endcase
            end
        end
    endtask

    task automatic sample();
        @(negedge i_clk);
        compare_model();
    endtask

    task automatic advance();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        i_rst = 1; i_clk_en = 1;
        {i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w} = '0;
        {i_load_e, i_reg_write_m, i_reg_write_w, i_dmem_busy_m, i_halt_req} = '0;
        i_pc_src_e = 2'b00;
    endtask

    // reset for one edge, then pass FILL so the DUT is in RUN
    task automatic reset_to_run();
        i_rst = 0; advance();
        i_rst = 1; sample(); advance();
    endtask

    initial begin
        idle_inputs();
        i_rst = 0;
        advance();

        // 1. reset outputs, one FILL cycle, then RUN
        sample();
        chk("rst_pc", 8'(o_pc_wr_en_h), 8'd0);
        chk("rst_ifflush", 8'(o_if_id_flush_h), 8'd1);
        chk("rst_idflush", 8'(o_id_ex_flush_h), 8'd1);
        advance();
        i_rst = 1;
        sample();
        chk("fill_state", 8'(o_state), 8'd0);
        chk("fill_pc", 8'(o_pc_wr_en_h), 8'd1);
        chk("fill_ifflush", 8'(o_if_id_flush_h), 8'd1);
        advance();
        sample();
        chk("run_state", 8'(o_state), 8'd1);
        chk("run_ifflush", 8'(o_if_id_flush_h), 8'd0);
        advance();

        // 2. load-use bubble, and rd_e=x0 never stalls
        i_load_e = 1; i_rd_e = 5; i_rs1_d = 5;
        sample();
        chk("lu_pc", 8'(o_pc_wr_en_h), 8'd0);
        chk("lu_stall", 8'(o_if_id_stall_h), 8'd1);
        chk("lu_idflush", 8'(o_id_ex_flush_h), 8'd1);
        advance();
        i_load_e = 0; i_rd_e = 0;
        sample();
        chk("lu_done_stall", 8'(o_if_id_stall_h), 8'd0);
        advance();
        i_load_e = 1; i_rd_e = 0; i_rs1_d = 0;
        sample();
        chk("lu_x0_stall", 8'(o_if_id_stall_h), 8'd0);
        chk("lu_x0_pc", 8'(o_pc_wr_en_h), 8'd1);
        advance();

        // 3. redirect beats load-use
        i_rd_e = 5; i_rs2_d = 5; i_pc_src_e = 2'b01;
        sample();
        chk("rd_ifflush", 8'(o_if_id_flush_h), 8'd1);
        chk("rd_idflush", 8'(o_id_ex_flush_h), 8'd1);
        chk("rd_pc", 8'(o_pc_wr_en_h), 8'd1);
        chk("rd_stall", 8'(o_if_id_stall_h), 8'd0);
        advance();
        idle_inputs();

        // 4. forwarding priority
        i_rs1_e = 7; i_rd_m = 7; i_rd_w = 7; i_reg_write_m = 1; i_reg_write_w = 1;
        sample(); chk("fwd_mem", 8'(o_fwd_a_e), 8'h2); advance();
        i_reg_write_m = 0;
        sample(); chk("fwd_wb", 8'(o_fwd_a_e), 8'h1); advance();
        i_rs1_e = 0; i_rd_w = 0;
        sample(); chk("fwd_x0", 8'(o_fwd_a_e), 8'h0); advance();
        idle_inputs();

        // 5a. four busy cycles in RUN, then back
        i_dmem_busy_m = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("busy_freeze", 8'(o_freeze_h), 8'd1);
            chk("busy_pc", 8'(o_pc_wr_en_h), 8'd0);
            chk("busy_state", 8'(o_state), (i == 0) ? 8'd1 : 8'd2);
            advance();
        end
        i_dmem_busy_m = 0;
        sample(); chk("busy_ret_pc", 8'(o_pc_wr_en_h), 8'd1); advance();
        sample(); chk("busy_ret_state", 8'(o_state), 8'd1); advance();

        // clk_en low holds the state even with busy asserted
        i_clk_en = 0; i_dmem_busy_m = 1;
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        chk("clken_hold", 8'(o_state), 8'd1);
        i_clk_en = 1; i_dmem_busy_m = 0;

        // 5b. 255 busy cycles set the sticky timeout
        i_dmem_busy_m = 1;
        for (int i = 0; i < 255; i++) begin
            sample();
            if (i == 254) chk("timeout_early", 8'(o_mem_timeout), 8'd0);
            advance();
        end
        sample(); chk("timeout_set", 8'(o_mem_timeout), 8'd1); advance();
        i_dmem_busy_m = 0;
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        chk("timeout_sticky", 8'(o_mem_timeout), 8'd1);
        reset_to_run();
        sample(); chk("timeout_clr", 8'(o_mem_timeout), 8'd0); advance();

        // 6a. halt: three DRAIN cycles then HALTED, resume via FILL
        i_halt_req = 1;
        sample(); advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("drain_state", 8'(o_state), 8'd3);
            chk("drain_pc", 8'(o_pc_wr_en_h), 8'd0);
            advance();
        end
        sample(); chk("halted", 8'(o_halted), 8'd1); advance();
        i_halt_req = 0;
        sample(); advance();
        sample(); chk("resume_fill", 8'(o_state), 8'd0); advance();
        sample(); chk("resume_run", 8'(o_state), 8'd1); advance();

        // 6b. two busy cycles mid-drain stretch it to five cycles
        i_halt_req = 1;
        sample(); advance();
        sample(); advance();
        i_dmem_busy_m = 1;
        sample(); advance();
        sample(); advance();
        i_dmem_busy_m = 0;
        sample(); advance();
        sample(); chk("drain_ext_not_yet", 8'(o_halted), 8'd0); advance();
        sample(); chk("drain_ext_halted", 8'(o_halted), 8'd1); advance();
        i_halt_req = 0;
        sample(); advance();
        sample(); advance();

        // 6c. reset during DRAIN
        i_halt_req = 1;
        sample(); advance();
        sample(); advance();
        i_rst = 0; i_halt_req = 0;
        sample(); advance();
        i_rst = 1;
        sample(); chk("drain_rst_fill", 8'(o_state), 8'd0); advance();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            i_rst         = ($urandom_range(0, 199) != 0);
            i_clk_en      = ($urandom_range(0, 9) < 8);
            i_rs1_d       = 5'($urandom_range(0, 7));
            i_rs2_d       = 5'($urandom_range(0, 7));
            i_rs1_e       = 5'($urandom_range(0, 7));
            i_rs2_e       = 5'($urandom_range(0, 7));
            i_rd_e        = 5'($urandom_range(0, 7));
            i_rd_m        = 5'($urandom_range(0, 7));
            i_rd_w        = 5'($urandom_range(0, 7));
            i_load_e      = 1'($urandom_range(0, 1));
            i_reg_write_m = 1'($urandom_range(0, 1));
            i_reg_write_w = 1'($urandom_range(0, 1));
            i_pc_src_e    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            i_dmem_busy_m = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) i_halt_req = ~i_halt_req;
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
